// File: rtl/memref_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// memref_sweep_checker_if
// Bundles the checker's control, memory-port and result signals.
//   master : checker side (drives strobes, addresses, write data, results)
//   slave  : environment side (drives tstart and the read response)
// Signals:
//   tstart                      start pulse
//   wr_en / wr_addr / din       memory write port
//   rd_en / rd_addr             memory read request
//   dout_valid / dout           memory read response
//   busy / done                 sweep status
//   err_count / first_err_addr / err_seen   check results
// ---------------------------------------------------------------------------
interface memref_sweep_checker_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 3
);
    logic             tstart;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             dout_valid;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             done;
    logic [15:0]      err_count;
    logic [AW-1:0]    first_err_addr;
    logic             err_seen;

    modport master (
        input  tstart,
        input  dout_valid,
        input  dout,
        output wr_en,
        output wr_addr,
        output din,
        output rd_en,
        output rd_addr,
        output busy,
        output done,
        output err_count,
        output first_err_addr,
        output err_seen
    );

    modport slave (
        output tstart,
        output dout_valid,
        output dout,
        input  wr_en,
        input  wr_addr,
        input  din,
        input  rd_en,
        input  rd_addr,
        input  busy,
        input  done,
        input  err_count,
        input  first_err_addr,
        input  err_seen
    );
endinterface

// File: rtl/memref_sweep_checker.sv
// ---------------------------------------------------------------------------
// memref_sweep_checker
// Writes exp(a) = SEED + a*STRIDE (mod 2^WIDTH) to every word of a memory,
// reads every word back one request per cycle, and checks each response for
// data and for arrival exactly RD_LATENCY cycles after its request.
// Ports:
//   i_clk   clock, all logic on posedge
//   i_rst   synchronous active-high reset
//   io_mem  memref_sweep_checker_if master: tstart in, write/read strobes out,
//           read response in, busy/done/err_count/first_err_addr/err_seen out
// Parameters: WIDTH, SIZE (>= 2), SEED, STRIDE, RD_LATENCY (>= 1).
// ---------------------------------------------------------------------------
module memref_sweep_checker #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      SIZE       = 8,
    parameter logic [WIDTH-1:0] SEED       = '0,
    parameter logic [WIDTH-1:0] STRIDE     = WIDTH'(1),
    parameter int unsigned      RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    memref_sweep_checker_if.master io_mem
);

    localparam int unsigned AW = $clog2(SIZE);
    localparam int unsigned DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StDone
    } state_e;

    // Expected word at an address; product truncated to WIDTH bits.
    function automatic logic [WIDTH-1:0] f_exp(input logic [AW-1:0] a);
        logic [WIDTH-1:0] w_a;
        w_a = WIDTH'(a);
        return SEED + w_a * STRIDE;
    endfunction

    state_e           r_state;
    logic [AW-1:0]    r_cnt;
    logic [DW-1:0]    r_drain;
    logic             r_wr_en;
    logic [AW-1:0]    r_wr_addr;
    logic [WIDTH-1:0] r_din;
    logic             r_rd_en;
    logic [AW-1:0]    r_rd_addr;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_err_count;
    logic [AW-1:0]    r_first_err_addr;
    logic             r_err_seen;
    logic             r_mis_seen;  // a data mismatch has already been latched this run

    // Pending-read pipeline: slot 0 holds the read issued last cycle, the
    // head (RD_LATENCY-1) is the read whose response is due this cycle.
    logic [RD_LATENCY-1:0] r_sr_pend;
    logic [AW-1:0]         r_sr_addr [RD_LATENCY];

    logic          w_head_pend;
    logic [AW-1:0] w_head_addr;
    logic          w_data_err;
    logic          w_miss_err;
    logic          w_spur_err;
    logic          w_err;
    logic          w_start;

    assign w_head_pend = r_sr_pend[RD_LATENCY-1];
    assign w_head_addr = r_sr_addr[RD_LATENCY-1];
    assign w_data_err  = w_head_pend && io_mem.dout_valid && (io_mem.dout != f_exp(w_head_addr));
    assign w_miss_err  = w_head_pend && !io_mem.dout_valid;
    assign w_spur_err  = !w_head_pend && io_mem.dout_valid;
    assign w_err       = w_data_err || w_miss_err || w_spur_err;
    assign w_start     = ((r_state == StIdle) || (r_state == StDone)) && io_mem.tstart;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= StIdle;
            r_cnt            <= '0;
            r_drain          <= '0;
            r_wr_en          <= 1'b0;
            r_wr_addr        <= '0;
            r_din            <= '0;
            r_rd_en          <= 1'b0;
            r_rd_addr        <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_err_seen       <= 1'b0;
            r_mis_seen       <= 1'b0;
            r_sr_pend        <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_sr_addr[i] <= '0;
            end
        end else begin
            r_sr_pend[0] <= r_rd_en;
            r_sr_addr[0] <= r_rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_sr_pend[i] <= r_sr_pend[i-1];
                r_sr_addr[i] <= r_sr_addr[i-1];
            end

            // A new run starts from clean results; a check failing on the
            // start edge belongs to the old run and is discarded.
            if (w_start) begin
                r_err_count      <= '0;
                r_first_err_addr <= '0;
                r_err_seen       <= 1'b0;
                r_mis_seen       <= 1'b0;
            end else if (w_err) begin
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
                r_err_seen <= 1'b1;
                if (w_data_err && !r_mis_seen) begin
                    r_first_err_addr <= w_head_addr;
                    r_mis_seen       <= 1'b1;
                end
            end

            case (r_state)
                StIdle, StDone: begin
                    if (io_mem.tstart) begin
                        r_state   <= StWrite;
                        r_cnt     <= '0;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                        r_din     <= SEED;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                StWrite: begin
                    if (r_cnt == AW'(SIZE - 1)) begin
                        r_state   <= StRead;
                        r_cnt     <= '0;
                        r_wr_en   <= 1'b0;
                        r_wr_addr <= '0;
                        r_din     <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                    end else begin
                        r_cnt     <= r_cnt + AW'(1);
                        r_wr_addr <= r_cnt + AW'(1);
                        r_din     <= f_exp(r_cnt + AW'(1));
                    end
                end
                StRead: begin
                    if (r_cnt == AW'(SIZE - 1)) begin
                        r_state   <= StDrain;
                        r_cnt     <= '0;
                        r_rd_en   <= 1'b0;
                        r_rd_addr <= '0;
                        r_drain   <= '0;
                    end else begin
                        r_cnt     <= r_cnt + AW'(1);
                        r_rd_addr <= r_cnt + AW'(1);
                    end
                end
                StDrain: begin
                    if (r_drain == DW'(RD_LATENCY - 1)) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_mem.wr_en          = r_wr_en;
    assign io_mem.wr_addr        = r_wr_addr;
    assign io_mem.din            = r_din;
    assign io_mem.rd_en          = r_rd_en;
    assign io_mem.rd_addr        = r_rd_addr;
    assign io_mem.busy           = r_busy;
    assign io_mem.done           = r_done;
    assign io_mem.err_count      = r_err_count;
    assign io_mem.first_err_addr = r_first_err_addr;
    assign io_mem.err_seen       = r_err_seen;

endmodule
